noc_flit_sink: RTL and testbench
================================

Name: noc_flit_sink

Overview:
- Ejection-side endpoint for one mesh node.
- Consumes 8-bit flits leaving a router's local output port and checks routing (destination match).
- Checks payload integrity against a local 6-bit LFSR that mirrors the source-side LFSR traffic generator.
- Exposes 8-bit saturating packet and error counters for top-level observation.

Parameters:
- MY_X, 0, X coordinate of this node (3 bits used).
- MY_Y, 0, Y coordinate of this node (3 bits used).
- MAX_LEN, 8, maximum flits per packet including head and tail; range 2..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flit_in  input  8  flit from router local output.
- flit_valid  input  1  flit_in valid this cycle.
- flit_ready  output  1  sink can accept; a transfer occurs when flit_valid && flit_ready.
- pkt_count  output  8  good packets received; saturates at 8'hFF.
- err_count  output  8  protocol, payload and length errors; saturates at 8'hFF.
- misroute_count  output  8  packets whose head destination is not (MY_X,MY_Y); saturates at 8'hFF.
- pkt_done  output  1  one-cycle pulse when a tail is accepted for a packet that completed without error.
- last_seed  output  6  head payload of the most recent head flit accepted.

Behaviour:
- Flit format: [7:6] type. 2'b01 = head, 2'b00 = body, 2'b10 = tail, 2'b11 = single (head+tail).
  - Head/single payload [5:3] = dest X, [2:0] = dest Y.
  - Body/tail payload [5:0] = LFSR data.
- Reset (synchronous, active-high): all counters 0, pkt_done 0, last_seed 0, FSM = IDLE, LFSR = 6'h01, flen = 0. flit_ready is 0 during the reset cycle and 1 otherwise (see optional feature).
- LFSR: 6-bit Fibonacci, taps x^6+x^5+1, next = {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - On an accepted head, seed = head[5:0]; if that value is 0, seed = 6'h01.
  - Each accepted body/tail flit must equal the current LFSR value; the LFSR then advances once.
- FSM states: IDLE, BODY, DRAIN. Only accepted flits cause transitions; there is no transition when no transfer occurs.
- IDLE:
  - head, dest match -> BODY; flen = 1; LFSR seeded; last_seed updated.
  - head, dest mismatch -> misroute_count+1 -> DRAIN.
  - single, dest match -> pkt_count+1, pkt_done pulse, stay IDLE.
  - single, dest mismatch -> misroute_count+1, stay IDLE.
  - body or tail -> err_count+1, flit dropped, stay IDLE.
- BODY:
  - body, data matches -> flen+1, stay BODY.
  - tail, data matches -> pkt_count+1, pkt_done pulse -> IDLE.
  - body/tail data mismatch -> err_count+1. Tail -> IDLE; body -> DRAIN.
  - flen reaching MAX_LEN-1 on a body flit -> err_count+1 -> DRAIN (length overrun).
  - head or single -> err_count+1 (missing tail). The new flit is then processed exactly as in IDLE, in the same cycle.
- DRAIN:
  - body -> discarded, no counter change, stay DRAIN.
  - tail -> discarded, no counter change -> IDLE.
  - head/single -> err_count+1, then processed as in IDLE.
- Counter increments are 1 per cycle maximum per counter. A single flit can increment both err_count and misroute_count (missing tail followed by a mismatched head).
- All counters saturate: once at 8'hFF they hold.
- pkt_done is registered; it is high in the cycle after the accepting edge, for exactly one cycle.
- Reset asserted mid-packet: packet is abandoned, all state returns to reset values, and no counter is incremented.

Optional Feature:
- NOC_SINK_BACKPRESSURE_EN.
- Defined: a second 6-bit LFSR (same taps, reset 6'h2A) advances every cycle. flit_ready = ~reset & ~bp_lfsr[0]. This gives pseudo-random stalls to exercise router credit/hold logic. FSM and checking are unchanged; only accepted transfers count.
- Undefined: flit_ready = ~reset, constant 1 after reset.

Test Plan:
- Reset, then a single flit 8'hC0 with MY_X=0, MY_Y=0 -> pkt_count=1, pkt_done pulses one cycle, err_count=0.
- Head 8'h45 (dest 0,5 with MY=(0,5)), then bodies 6'h05 and 6'h0A, then tail 6'h14 (i.e. 8'h94) -> pkt_count=1, last_seed=6'h05, err_count=0.
- Same packet with the second body corrupted to 6'h0B -> err_count=1; remaining flits drained; pkt_count=0; next valid packet counted normally.
- Head to dest (1,1) at node (0,0), followed by 2 bodies and a tail -> misroute_count=1, err_count=0, FSM back to IDLE after the tail.
- Head, one body, then a new head without a tail -> err_count=1; second packet completes -> pkt_count=1. Separately, 300 single flits -> pkt_count holds at 8'hFF.
- Assert reset mid-packet, then send a fresh full packet -> all counters 0 after reset; fresh packet gives pkt_count=1. With NOC_SINK_BACKPRESSURE_EN defined, flit_ready toggles and the same counts result when the source holds flits until ready.

Source files
------------

// File: rtl/noc_flit_sink.sv
`default_nettype none
// ============================================================================
//  Module   : noc_flit_sink
//  Purpose  : Ejection-side endpoint for one mesh node. Accepts 8-bit flits
//             from the router's local output port, checks that each packet
//             was routed here, checks body/tail payloads against a local
//             6-bit LFSR mirroring the source generator, and keeps
//             saturating good-packet, error and misroute counters.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             flit_in/flit_valid  - incoming flit and its valid qualifier
//             flit_ready          - sink can accept (transfer = valid&ready)
//             pkt_count           - good packets received (saturating)
//             err_count           - protocol/payload/length errors (sat.)
//             misroute_count      - packets not addressed to this node (sat.)
//             pkt_done            - 1-cycle pulse after a clean tail/single
//             last_seed           - payload of the last matching head flit
//  Options  : NOC_SINK_BACKPRESSURE_EN - pseudo-random stalls on flit_ready
//  Revision : 1.0 - initial release
// ============================================================================
module noc_flit_sink #(
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0,
    parameter int MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] flit_in,
    input  logic       flit_valid,
    output logic       flit_ready,
    output logic [7:0] pkt_count,
    output logic [7:0] err_count,
    output logic [7:0] misroute_count,
    output logic       pkt_done,
    output logic [5:0] last_seed
);

    localparam logic [1:0] c_TYPE_BODY   = 2'b00;
    localparam logic [1:0] c_TYPE_HEAD   = 2'b01;
    localparam logic [1:0] c_TYPE_TAIL   = 2'b10;
    localparam logic [1:0] c_TYPE_SINGLE = 2'b11;
    localparam logic [2:0] c_MY_X        = 3'(MY_X);
    localparam logic [2:0] c_MY_Y        = 3'(MY_Y);
    // A body arriving when this many flits are already in means the tail
    // could no longer fit inside MAX_LEN.
    localparam logic [3:0] c_LEN_LIMIT   = 4'(MAX_LEN - 1);
    localparam logic [5:0] c_LFSR_RESET  = 6'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_lfsr, w_lfsr_nxt;
    logic [3:0] r_flen, w_flen_nxt;
    logic [5:0] r_last_seed, w_seed_nxt;
    logic [7:0] r_pkt_count, r_err_count, r_mis_count;
    logic       r_pkt_done;

    logic       w_xfer;
    logic [1:0] w_type;
    logic [5:0] w_payload;
    logic       w_dest_match;
    logic [5:0] w_head_seed;
    logic       w_idle_proc;
    logic       w_inc_pkt, w_inc_err, w_inc_mis, w_done;

    function automatic logic [5:0] lfsr_step(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
`ifdef NOC_SINK_BACKPRESSURE_EN
    logic [5:0] r_bp_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bp_lfsr <= 6'h2A;
        end else begin
            r_bp_lfsr <= lfsr_step(r_bp_lfsr);
        end
    end

    assign flit_ready = ~reset & ~r_bp_lfsr[0];
`else
    assign flit_ready = ~reset;
`endif

    assign w_xfer       = flit_valid & flit_ready;
    assign w_type       = flit_in[7:6];
    assign w_payload    = flit_in[5:0];
    assign w_dest_match = (flit_in[5:3] == c_MY_X) && (flit_in[2:0] == c_MY_Y);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign w_head_seed  = (w_payload == 6'h00) ? c_LFSR_RESET : w_payload;

    // ------------------------------------------------------------------
    // Next-state / event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_flen_nxt  = r_flen;
        w_seed_nxt  = r_last_seed;
        w_inc_pkt   = 1'b0;
        w_inc_err   = 1'b0;
        w_inc_mis   = 1'b0;
        w_done      = 1'b0;
        w_idle_proc = 1'b0;

        if (w_xfer) begin
            case (r_state)
                ST_IDLE: w_idle_proc = 1'b1;
                ST_BODY: begin
                    case (w_type)
                        c_TYPE_BODY: begin
                            if (r_flen >= c_LEN_LIMIT) begin
                                w_inc_err   = 1'b1;
                                w_state_nxt = ST_DRAIN;
                            end else if (w_payload != r_lfsr) begin
                                w_inc_err   = 1'b1;
                                w_state_nxt = ST_DRAIN;
                            end else begin
                                w_flen_nxt = r_flen + 4'd1;
                                w_lfsr_nxt = lfsr_step(r_lfsr);
                            end
                        end
                        c_TYPE_TAIL: begin
                            if (w_payload == r_lfsr) begin
                                w_inc_pkt = 1'b1;
                                w_done    = 1'b1;
                            end else begin
                                w_inc_err = 1'b1;
                            end
                            w_lfsr_nxt  = lfsr_step(r_lfsr);
                            w_state_nxt = ST_IDLE;
                        end
                        default: begin
                            // Head/single while a packet is open: the open
                            // packet lost its tail; the new flit starts over.
                            w_inc_err   = 1'b1;
                            w_idle_proc = 1'b1;
                        end
                    endcase
                end
                ST_DRAIN: begin
                    case (w_type)
                        c_TYPE_BODY: ;
                        c_TYPE_TAIL: w_state_nxt = ST_IDLE;
                        default: begin
                            w_inc_err   = 1'b1;
                            w_idle_proc = 1'b1;
                        end
                    endcase
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            // Start-of-packet handling, shared by IDLE and by a head/single
            // that interrupts BODY or DRAIN.
            if (w_idle_proc) begin
                case (w_type)
                    c_TYPE_HEAD: begin
                        if (w_dest_match) begin
                            w_state_nxt = ST_BODY;
                            w_flen_nxt  = 4'd1;
                            w_lfsr_nxt  = w_head_seed;
                            w_seed_nxt  = w_payload;
                        end else begin
                            w_inc_mis   = 1'b1;
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                    c_TYPE_SINGLE: begin
                        if (w_dest_match) begin
                            w_inc_pkt = 1'b1;
                            w_done    = 1'b1;
                        end else begin
                            w_inc_mis = 1'b1;
                        end
                        w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_inc_err   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= c_LFSR_RESET;
            r_flen      <= 4'd0;
            r_last_seed <= 6'h00;
            r_pkt_count <= 8'h00;
            r_err_count <= 8'h00;
            r_mis_count <= 8'h00;
            r_pkt_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_flen      <= w_flen_nxt;
            r_last_seed <= w_seed_nxt;
            r_pkt_count <= sat_inc(r_pkt_count, w_inc_pkt);
            r_err_count <= sat_inc(r_err_count, w_inc_err);
            r_mis_count <= sat_inc(r_mis_count, w_inc_mis);
            r_pkt_done  <= w_done;
        end
    end

    assign pkt_count      = r_pkt_count;
    assign err_count      = r_err_count;
    assign misroute_count = r_mis_count;
    assign pkt_done       = r_pkt_done;
    assign last_seed      = r_last_seed;

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_flit_sink
//  Purpose  : Self-checking bench for noc_flit_sink (node MY=(0,5)).
//             Directed packet scenarios followed by randomized packet
//             traffic scored against a packet-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_flit_sink;

    localparam int MY_X    = 0;
    localparam int MY_Y    = 5;
    localparam int MAX_LEN = 8;
    localparam logic [2:0] c_MX = 3'(MY_X);
    localparam logic [2:0] c_MY = 3'(MY_Y);

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] flit_in;
    logic       flit_valid;
    logic       flit_ready;
    logic [7:0] pkt_count;
    logic [7:0] err_count;
    logic [7:0] misroute_count;
    logic       pkt_done;
    logic [5:0] last_seed;

    noc_flit_sink #(
        .MY_X    (MY_X),
        .MY_Y    (MY_Y),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flit_in        (flit_in),
        .flit_valid     (flit_valid),
        .flit_ready     (flit_ready),
        .pkt_count      (pkt_count),
        .err_count      (err_count),
        .misroute_count (misroute_count),
        .pkt_done       (pkt_done),
        .last_seed      (last_seed)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int e_pkt, e_err, e_mis;
    logic [7:0] pq[$];

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [5:0] lnext(input logic [5:0] x);
        return 6'(((x << 1) & 6'h3F) | (((x >> 5) ^ (x >> 4)) & 6'h01));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".pkt"}, 32'(pkt_count), 32'(sat(e_pkt)));
        check({tag, ".err"}, 32'(err_count), 32'(sat(e_err)));
        check({tag, ".mis"}, 32'(misroute_count), 32'(sat(e_mis)));
    endtask

    // Drive one flit and hold it until the sink accepts it; returns on the
    // falling edge after the accepting rising edge.
    task automatic send(input logic [7:0] f);
        int n;
        n = 0;
        flit_in    = f;
        flit_valid = 1'b1;
        while (!flit_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nfail++;
            $error("FAIL ready_timeout: flit_ready observed 0 expected 1");
        end
        @(negedge clk);
        flit_valid = 1'b0;
    endtask

    task automatic send_q();
        foreach (pq[j]) send(pq[j]);
        pq.delete();
    endtask

    // Build a packet to (dx,dy) with nb bodies; bad selects a corrupted
    // flit (0..nb-1 body, nb tail, -1 none).
    task automatic mk_pkt(input logic [2:0] dx, input logic [2:0] dy, input int nb,
                          input int bad, input bit with_tail);
        logic [5:0] hp, s, d;
        hp = {dx, dy};
        pq.push_back({2'b01, hp});
        s = (hp == 6'h00) ? 6'h01 : hp;
        for (int j = 0; j < nb; j++) begin
            d = s;
            if (bad == j) d = s ^ 6'($urandom_range(1, 63));
            pq.push_back({2'b00, d});
            s = lnext(s);
        end
        if (with_tail) begin
            d = s;
            if (bad == nb) d = s ^ 6'($urandom_range(1, 63));
            pq.push_back({2'b10, d});
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        flit_valid = 1'b0;
        #1;
        check("ready_in_reset", 32'(flit_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        e_pkt = 0; e_err = 0; e_mis = 0;
        #1;
        check("ready_after_reset", 32'(flit_ready), 32'd1);
        check_counts("reset");
        check("reset.done", 32'(pkt_done), 32'd0);
        check("reset.seed", 32'(last_seed), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k, nb, pend;
        logic [2:0] dx, dy;
        bit  exp_done;

        reset      = 1'b1;
        flit_valid = 1'b0;
        flit_in    = 8'h00;
        @(negedge clk);
        apply_reset();

        // Single addressed to this node, pkt_done lasts one cycle
        send(8'hC5); e_pkt++;
        check_counts("single");
        check("single.done", 32'(pkt_done), 32'd1);
        @(negedge clk);
        check("single.done_off", 32'(pkt_done), 32'd0);

        // Reference packet: seed 05 -> 05, 0A, 14
        pq = '{8'h45, 8'h05, 8'h0A, 8'h94}; send_q(); e_pkt++;
        check_counts("good");
        check("good.done", 32'(pkt_done), 32'd1);
        check("good.seed", 32'(last_seed), 32'h05);

        // Corrupted second body, drained, then a clean packet
        pq = '{8'h45, 8'h05, 8'h0B, 8'h94}; send_q(); e_err++;
        check_counts("corrupt");
        check("corrupt.done", 32'(pkt_done), 32'd0);
        pq = '{8'h45, 8'h05, 8'h0A, 8'h94}; send_q(); e_pkt++;
        check_counts("after_corrupt");

        // Misrouted head to (1,1): drained, back to IDLE after tail
        pq = '{8'h49, 8'h05, 8'h3F, 8'h94}; send_q(); e_mis++;
        check_counts("misroute");
        send(8'hC5); e_pkt++;
        check_counts("misroute.idle");

        // Missing tail then a complete packet
        pq = '{8'h45, 8'h05}; send_q();
        pq = '{8'h45, 8'h05, 8'h0A, 8'h94}; send_q(); e_err++; e_pkt++;
        check_counts("missing_tail");

        // Stray body and tail while idle
        send(8'h05); e_err++;
        check_counts("stray_body");
        send(8'h94); e_err++;
        check_counts("stray_tail");

        // Length overrun (8 bodies) and a 7-flit packet within MAX_LEN
        mk_pkt(c_MX, c_MY, 8, -1, 1'b1); send_q(); e_err++;
        check_counts("overrun");
        mk_pkt(c_MX, c_MY, 5, -1, 1'b1); send_q(); e_pkt++;
        check_counts("long_ok");
        check("long_ok.done", 32'(pkt_done), 32'd1);

        // Head arriving in DRAIN
        pq = '{8'h49, 8'h00}; send_q(); e_mis++;
        pq = '{8'h45, 8'h05, 8'h0A, 8'h94}; send_q(); e_err++; e_pkt++;
        check_counts("drain_head");

        // Missing tail followed by misrouted head: both counters step
        pq = '{8'h45, 8'h05}; send_q();
        send(8'h49); e_err++; e_mis++;
        check_counts("mistail_misroute");
        send(8'h94);

        // Saturation of pkt_count
        for (int i = 0; i < 300; i++) send(8'hC5);
        e_pkt += 300;
        check_counts("saturate");

        // Reset in the middle of a packet
        pq = '{8'h45, 8'h05}; send_q();
        apply_reset();
        pq = '{8'h45, 8'h05, 8'h0A, 8'h94}; send_q(); e_pkt++;
        check_counts("post_reset");
        check("post_reset.seed", 32'(last_seed), 32'h05);

        // Randomized packet traffic
        pend = 0;
        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 7));
            if (k == 6 && pend != 0) k = 1;
            e_err += pend;
            pend  = 0;
            exp_done = 1'b0;
            nb = int'($urandom_range(0, 5));
            do begin
                dx = 3'($urandom);
                dy = 3'($urandom);
            end while (dx == c_MX && dy == c_MY);
            case (k)
                0: begin mk_pkt(c_MX, c_MY, nb, -1, 1'b1); e_pkt++; exp_done = 1'b1; end
                1: begin pq.push_back({2'b11, c_MX, c_MY}); e_pkt++; exp_done = 1'b1; end
                2: begin mk_pkt(dx, dy, nb, -1, 1'b1); e_mis++; end
                3: begin pq.push_back({2'b11, dx, dy}); e_mis++; end
                4: begin
                    nb = int'($urandom_range(1, 5));
                    mk_pkt(c_MX, c_MY, nb, int'($urandom_range(0, nb)), 1'b1);
                    e_err++;
                end
                5: begin mk_pkt(c_MX, c_MY, int'($urandom_range(0, 3)), -1, 1'b0); pend = 1; end
                6: begin
                    pq.push_back({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 6'($urandom)});
                    e_err++;
                end
                default: begin
                    mk_pkt(c_MX, c_MY, int'($urandom_range(7, 8)), -1, 1'b1);
                    e_err++;
                end
            endcase
            send_q();
            check("rand.done", 32'(pkt_done), 32'(exp_done));
            check_counts("rand");
            check("rand.seed", 32'(last_seed), 32'h05);
        end
        if (pend != 0) begin
            send({2'b11, c_MX, c_MY});
            e_err++; e_pkt++;
            check_counts("rand_flush");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
